// File: rtl/fpu_requester.sv
// CPU-side initiator for the FPU stb/ack protocol: one op in via valid/ready, operands strobed out,
// result acknowledged and returned with error flag and SEND+WAIT latency; watchdog aborts stuck ops.
module fpu_requester #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic [CNT_W-1:0] resp_cycles,
    output logic [3:0]       fpu_op,
    output logic [31:0]      fpu_in1,
    output logic [31:0]      fpu_in2,
    output logic             fpu_in1_stb,
    output logic             fpu_in2_stb,
    input  logic             fpu_in1_ack,
    input  logic             fpu_in2_ack,
    input  logic [31:0]      fpu_out,
    input  logic             fpu_out_stb,
    output logic             fpu_out_ack
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_ACK  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        fpu_op_q, fpu_op_d;
    logic [31:0]       fpu_in1_q, fpu_in1_d;
    logic [31:0]       fpu_in2_q, fpu_in2_d;
    logic              in1_stb_q, in1_stb_d;
    logic              in2_stb_q, in2_stb_d;
    logic              out_ack_q, out_ack_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [CNT_W-1:0]  resp_cycles_q, resp_cycles_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              op_legal;
    logic              busy;
    logic              timeout;
    logic              send_done;
    logic [CNT_W-1:0]  cnt_inc;

    assign op_legal  = (req_op <= 4'hA);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign busy      = (state_q == S_SEND) || (state_q == S_WAIT);
    assign timeout   = busy && (cnt_inc >= TIMEOUT_C);
    // An operand whose strobe has already dropped was handshaken on an earlier edge.
    assign send_done = (!in1_stb_q || fpu_in1_ack) && (!in2_stb_q || fpu_in2_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req_valid) state_d = op_legal ? S_SEND : S_RESP;
            S_SEND: begin
                if (timeout)        state_d = S_RESP;
                else if (send_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timeout)          state_d = S_RESP;
                else if (fpu_out_stb) state_d = S_ACK;
            end
            S_ACK:  state_d = S_RESP;
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fpu_op_d      = fpu_op_q;
        fpu_in1_d     = fpu_in1_q;
        fpu_in2_d     = fpu_in2_q;
        in1_stb_d     = in1_stb_q;
        in2_stb_d     = in2_stb_q;
        out_ack_d     = out_ack_q;
        resp_valid_d  = resp_valid_q;
        resp_err_d    = resp_err_q;
        resp_data_d   = resp_data_q;
        resp_cycles_d = resp_cycles_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    fpu_op_d  = req_op;
                    fpu_in1_d = req_a;
                    fpu_in2_d = req_b;
                    cnt_d     = '0;
                    if (op_legal) begin
                        in1_stb_d = 1'b1;
                        in2_stb_d = 1'b1;
                    end else begin
                        resp_valid_d  = 1'b1;
                        resp_err_d    = 1'b1;
                        resp_data_d   = '0;
                        resp_cycles_d = '0;
                    end
                end
            end
            S_SEND, S_WAIT: begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    in1_stb_d     = 1'b0;
                    in2_stb_d     = 1'b0;
                    out_ack_d     = 1'b0;
                    resp_valid_d  = 1'b1;
                    resp_err_d    = 1'b1;
                    resp_data_d   = '0;
                    resp_cycles_d = TIMEOUT_C;
                end else if (state_q == S_SEND) begin
                    if (in1_stb_q && fpu_in1_ack) in1_stb_d = 1'b0;
                    if (in2_stb_q && fpu_in2_ack) in2_stb_d = 1'b0;
                end else if (fpu_out_stb) begin
                    resp_data_d = fpu_out;
                    out_ack_d   = 1'b1;
                end
            end
            S_ACK: begin
                // One-cycle ack; a lingering out_stb is not a second result.
                out_ack_d     = 1'b0;
                resp_valid_d  = 1'b1;
                resp_err_d    = 1'b0;
                resp_cycles_d = cnt_q;
            end
            S_RESP: if (resp_ready) resp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_op_q      <= '0;
            fpu_in1_q     <= '0;
            fpu_in2_q     <= '0;
            in1_stb_q     <= 1'b0;
            in2_stb_q     <= 1'b0;
            out_ack_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_data_q   <= '0;
            resp_cycles_q <= '0;
            cnt_q         <= '0;
        end else begin
            fpu_op_q      <= fpu_op_d;
            fpu_in1_q     <= fpu_in1_d;
            fpu_in2_q     <= fpu_in2_d;
            in1_stb_q     <= in1_stb_d;
            in2_stb_q     <= in2_stb_d;
            out_ack_q     <= out_ack_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_data_q   <= resp_data_d;
            resp_cycles_q <= resp_cycles_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign resp_cycles = resp_cycles_q;
    assign fpu_op      = fpu_op_q;
    assign fpu_in1     = fpu_in1_q;
    assign fpu_in2     = fpu_in2_q;
    assign fpu_in1_stb = in1_stb_q;
    assign fpu_in2_stb = in2_stb_q;
    assign fpu_out_ack = out_ack_q;

endmodule
